// File: rtl/taylor_term_sequencer.sv
// Streams one sample against a coefficient table as Taylor term beats (x, table[k]) for k = L..0,
// then closes each series with a NaN sentinel beat flagged last.
module taylor_term_sequencer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_LINES = 5,
    parameter logic [DATA_WIDTH-1:0] NAN_WORD   = 32'h7F90_0000
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  coeff_we_i,
    input  logic [ADDR_LINES-1:0] coeff_waddr_i,
    input  logic [DATA_WIDTH-1:0] coeff_wdata_i,
    output logic                  wr_drop_o,
    input  logic [ADDR_LINES-1:0] taylor_length_i,
    input  logic                  x_valid_i,
    output logic                  x_ready_o,
    input  logic [DATA_WIDTH-1:0] x_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] signal_o,
    output logic [DATA_WIDTH-1:0] coeff_o,
    output logic                  last_o,
    output logic                  busy_o
);

    localparam int DEPTH = 2 ** ADDR_LINES;

    typedef enum logic [1:0] {IDLE, STREAM, SENTINEL} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] coeff_tbl [DEPTH];
    logic [ADDR_LINES-1:0] idx;
    logic [ADDR_LINES-1:0] idx_next;
    logic                  accept;
    logic                  xfer;
    logic                  tbl_wr;
    logic                  write_through;

    assign x_ready_o     = (state == IDLE);
    assign busy_o        = (state != IDLE);
    assign accept        = x_valid_i && x_ready_o;
    assign xfer          = out_valid_o && out_ready_i;
    assign tbl_wr        = coeff_we_i && (state == IDLE);
    assign write_through = tbl_wr && (coeff_waddr_i == taylor_length_i);
    assign idx_next      = idx - ADDR_LINES'(1);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            idx         <= '0;
            out_valid_o <= 1'b0;
            last_o      <= 1'b0;
            wr_drop_o   <= 1'b0;
            signal_o    <= '0;
            coeff_o     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                coeff_tbl[i] <= '0;
            end
        end else begin
            // Table writes only land while idle so a running series sees a frozen table.
            wr_drop_o <= coeff_we_i && (state != IDLE);
            if (tbl_wr) begin
                coeff_tbl[coeff_waddr_i] <= coeff_wdata_i;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= STREAM;
                        idx         <= taylor_length_i;
                        signal_o    <= x_data_i;
                        coeff_o     <= write_through ? coeff_wdata_i
                                                     : coeff_tbl[taylor_length_i];
                        last_o      <= 1'b0;
                        out_valid_o <= 1'b1;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (idx != '0) begin
                            idx     <= idx_next;
                            coeff_o <= coeff_tbl[idx_next];
                        end else begin
                            state    <= SENTINEL;
                            signal_o <= NAN_WORD;
                            coeff_o  <= NAN_WORD;
                            last_o   <= 1'b1;
                        end
                    end
                end
                SENTINEL: begin
                    if (xfer) begin
                        state       <= IDLE;
                        out_valid_o <= 1'b0;
                        last_o      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_o <= 1'b0;
                    last_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/taylor_term_sequencer.md
TAYLOR_TERM_SEQUENCER -- requirements
Module: taylor_term_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: FP32 word width of samples and coefficients.
REQ-002 SHALL have parameter ADDR_LINES, default 5: coefficient table address width, giving 2^ADDR_LINES entries.
REQ-003 SHALL have parameter NAN_WORD, default 32'h7F90_0000: end-of-series sentinel word.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rstn_i, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port coeff_we_i, input, 1 bit: coefficient table write strobe.
REQ-007 SHALL have port coeff_waddr_i, input, ADDR_LINES bits: table write index, equal to the Taylor term order.
REQ-008 SHALL have port coeff_wdata_i, input, DATA_WIDTH bits: coefficient word to write.
REQ-009 SHALL have port wr_drop_o, output, 1 bit: one-cycle pulse when a write is discarded.
REQ-010 SHALL have port taylor_length_i, input, ADDR_LINES bits: highest term order L.
REQ-011 SHALL have ports x_valid_i (input, 1), x_ready_o (output, 1) and x_data_i (input, DATA_WIDTH): sample handshake.
REQ-012 SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1): term handshake towards the MAC.
REQ-013 SHALL have ports signal_o (output, DATA_WIDTH), coeff_o (output, DATA_WIDTH) and last_o (output, 1): term payload to the MAC.
REQ-014 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, STREAM and SENTINEL.
REQ-016 x_ready_o SHALL be 1 only in IDLE.
REQ-017 Sample accept is x_valid_i && x_ready_o; transfer is out_valid_o && out_ready_i.
REQ-018 On accept at edge N, the block SHALL latch x_data_i and L, go to STREAM, and at N+1 present out_valid_o=1, signal_o=x, coeff_o=table[L], last_o=0, with index idx=L.
REQ-019 On a STREAM transfer with idx>0, the block SHALL set idx=idx-1 and coeff_o=table[idx-1]; signal_o SHALL hold x.
REQ-020 On a STREAM transfer with idx==0, the block SHALL go to SENTINEL with signal_o=coeff_o=NAN_WORD and last_o=1.
REQ-021 On a SENTINEL transfer, the block SHALL go to IDLE with out_valid_o=0; the next sample SHALL be accepted no earlier than one cycle later.
REQ-022 While out_valid_o=1 and out_ready_i=0, signal_o, coeff_o, last_o and out_valid_o SHALL hold stable, with no term skipped or repeated.
REQ-023 Each sample SHALL produce exactly L+1 term beats followed by one sentinel beat; L=0 gives one term beat then the sentinel.
REQ-024 A write in IDLE SHALL update table[coeff_waddr_i] at that edge.
REQ-025 A write while busy_o=1 SHALL be discarded, with wr_drop_o=1 in the next cycle.
REQ-026 For a write and a sample accept in the same IDLE cycle with coeff_waddr_i==taylor_length_i, the first coeff_o SHALL equal coeff_wdata_i (write-through).
REQ-027 Changes to taylor_length_i after accept SHALL have no effect until the next accept.
REQ-028 All payload outputs SHALL be registered, with no combinational path from out_ready_i to outputs other than x_ready_o.

Reset
REQ-029 With rstn_i=0 at an edge, the block SHALL enter IDLE; out_valid_o, last_o, busy_o and wr_drop_o SHALL be 0; signal_o, coeff_o and all table entries SHALL be 0; x_ready_o SHALL be 1 from the first cycle after reset.
REQ-030 Reset mid-STREAM or mid-SENTINEL SHALL abort the series with no sentinel emitted; the first accept after release SHALL start a fresh series.

Verification
REQ-031 SHALL cover: load table[0..2]=3F800000,40000000,40000000; L=2; x=3E2C8D3D; out_ready_i=1 -> beats (x,40000000),(x,40000000),(x,3F800000),(7F900000,7F900000,last=1) on consecutive cycles starting one cycle after accept.
REQ-032 SHALL cover: same stream with out_ready_i toggling 1,0,0,1,... -> identical beat sequence, payload stable during each stall.
REQ-033 SHALL cover: L=0, table[0]=3F800000 -> exactly one term beat (x,3F800000) then the sentinel.
REQ-034 SHALL cover: write table[1]=12345678 while busy -> wr_drop_o pulse; next series still emits the old table[1].
REQ-035 SHALL cover: write table[2]=AAAAAAAA in the accept cycle with L=2 -> first coeff_o=AAAAAAAA.
REQ-036 SHALL cover: rstn_i=0 for one cycle during the 2nd beat -> outputs 0, table cleared, x_ready_o=1 next cycle, no sentinel.
